fco_align_monitor: RTL and testbench

Frame-clock (FCO) alignment monitor in the ADC front-end DCO clock domain. Detects rising edges of the sampled FCO marker and checks that consecutive markers are exactly the expected number of word cycles apart. Declares lock after LOCK_COUNT consecutive good intervals. Flags and counts every timing violation.

---
 rtl/fco_align_monitor.sv | 162 ++++++++++++++++
 tb/tb_fco_align_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fco_align_monitor.sv
// Frame-clock (FCO) alignment monitor, DCO clock domain.
//
// Watches the sampled FCO marker for rising edges and checks that
// consecutive edges are exactly EXPECT_PERIOD+1 cycles apart. It declares
// lock after LOCK_COUNT consecutive good intervals. Every early or missing
// marker produces an error strobe and bumps a saturating error counter.
//
// Monitor state machine:
//   IDLE  : not armed. The first rising edge arms the monitor and starts
//           the gap measurement. It gives no pulse and no error.
//   ARMED : the gap counter runs. A rising edge with gap == EXPECT_PERIOD
//           is a good interval. A rising edge with a smaller gap is an
//           early marker; the monitor stays armed. Reaching EXPECT_PERIOD
//           without an edge is a missing or late marker; the monitor
//           disarms.
//
// Output timing: every output is registered. The outputs reflect the
// marker that was sampled at the same posedge.

module fco_align_monitor #(
  parameter int EXPECT_PERIOD = 8,
  parameter int LOCK_COUNT    = 3,
  parameter int ERR_W         = 16
) (
  input  logic             dco_clk,
  input  logic             rst_n,
  input  logic             fco_in,
  output logic             aligned,
  output logic             align_pulse,
  output logic             align_err_pulse,
  output logic [ERR_W-1:0] err_count
);

  // The gap counter must be able to hold EXPECT_PERIOD itself.
  localparam int GAP_W  = $clog2(EXPECT_PERIOD + 2);
  // The good counter saturates at LOCK_COUNT.
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [GAP_W-1:0]  GAP_TARGET = GAP_W'(EXPECT_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_MAX   = GOOD_W'(LOCK_COUNT);
  localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // Registered state.
  state_t            state_q;
  logic              fco_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GOOD_W-1:0] good_q;

  // Next-state values.
  state_t            state_d;
  logic [GAP_W-1:0]  gap_d;
  logic [GOOD_W-1:0] good_d;
  logic              aligned_d;
  logic              align_pulse_d;
  logic              align_err_pulse_d;
  logic [ERR_W-1:0]  err_count_d;

  // Combinational helpers.
  logic              rise;
  logic              violation;
  logic [GOOD_W-1:0] good_inc;

  // A rising edge is fco high now and low in the previous cycle.
  // fco_q resets to 0, so a marker already high just after reset
  // counts as an edge.
  assign rise = fco_in & ~fco_q;

  // Saturating increment of the good-interval counter.
  assign good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);

  // Next-state and output decode; defaults hold state and keep strobes low.
  always_comb begin
    state_d           = state_q;
    gap_d             = gap_q;
    good_d            = good_q;
    aligned_d         = aligned;
    align_pulse_d     = 1'b0;
    align_err_pulse_d = 1'b0;
    err_count_d       = err_count;
    violation         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only the first marker is awaited; no timing is judged.
        if (rise) begin
          state_d = ST_ARMED;
          gap_d   = '0;
        end
      end

      ST_ARMED: begin
        if (rise) begin
          // Each edge restarts the measurement, good or not.
          gap_d = '0;
          if (gap_q == GAP_TARGET) begin
            align_pulse_d = 1'b1;
            good_d        = good_inc;
            if (good_inc == GOOD_MAX) begin
              aligned_d = 1'b1;
            end
          end else begin
            // Early marker: flag it but stay armed.
            violation = 1'b1;
          end
        end else if (gap_q == GAP_TARGET) begin
          // The expected edge did not arrive: flag it and wait to re-arm.
          // A late marker can therefore never show gap > EXPECT_PERIOD.
          violation = 1'b1;
          state_d   = ST_IDLE;
          gap_d     = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase

    // Shared violation actions: drop lock, restart the good run and count.
    // The strobe still fires when the counter is saturated.
    if (violation) begin
      align_err_pulse_d = 1'b1;
      aligned_d         = 1'b0;
      good_d            = '0;
      if (err_count != ERR_MAX) begin
        err_count_d = err_count + ERR_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      fco_q           <= 1'b0;
      gap_q           <= '0;
      good_q          <= '0;
      aligned         <= 1'b0;
      align_pulse     <= 1'b0;
      align_err_pulse <= 1'b0;
      err_count       <= '0;
    end else begin
      state_q         <= state_d;
      fco_q           <= fco_in;
      gap_q           <= gap_d;
      good_q          <= good_d;
      aligned         <= aligned_d;
      align_pulse     <= align_pulse_d;
      align_err_pulse <= align_err_pulse_d;
      err_count       <= err_count_d;
    end
  end

endmodule

// File: tb/tb_fco_align_monitor.sv
// Directed testbench for fco_align_monitor.
// Two instances share the same stimulus. One uses the default parameters.
// The other uses ERR_W=2 so that saturation of the error counter can be
// observed. Inputs change 1 ns after a posedge. Outputs are sampled there
// as well, which shows the values registered at that posedge.

module tb_fco_align_monitor;

  localparam int EXPECT_PERIOD = 8;
  localparam int LOCK_COUNT    = 3;
  localparam int ERR_W         = 16;
  localparam int ERR_W_SAT     = 2;

  logic                 dco_clk;
  logic                 rst_n;
  logic                 fco_in;
  logic                 aligned;
  logic                 align_pulse;
  logic                 align_err_pulse;
  logic [ERR_W-1:0]     err_count;
  logic                 aligned_s;
  logic                 align_pulse_s;
  logic                 align_err_pulse_s;
  logic [ERR_W_SAT-1:0] err_count_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock and DUTs
  initial dco_clk = 1'b0;
  always #5 dco_clk = ~dco_clk;

  fco_align_monitor #(
    .EXPECT_PERIOD(EXPECT_PERIOD),
    .LOCK_COUNT   (LOCK_COUNT),
    .ERR_W        (ERR_W)
  ) dut (
    .dco_clk        (dco_clk),
    .rst_n          (rst_n),
    .fco_in         (fco_in),
    .aligned        (aligned),
    .align_pulse    (align_pulse),
    .align_err_pulse(align_err_pulse),
    .err_count      (err_count)
  );

  fco_align_monitor #(
    .EXPECT_PERIOD(EXPECT_PERIOD),
    .LOCK_COUNT   (LOCK_COUNT),
    .ERR_W        (ERR_W_SAT)
  ) dut_sat (
    .dco_clk        (dco_clk),
    .rst_n          (rst_n),
    .fco_in         (fco_in),
    .aligned        (aligned_s),
    .align_pulse    (align_pulse_s),
    .align_err_pulse(align_err_pulse_s),
    .err_count      (err_count_s)
  );

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drivers
  // Drive fco for one cycle. Return 1 ns after the sampling posedge.
  task automatic cyc(input logic f);
    fco_in = f;
    @(posedge dco_clk);
    #1;
  endtask

  // Low cycles in which neither strobe may fire.
  task automatic idle_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0);
      check({tag, "_idle_pulse"}, 32'(align_pulse), 32'd0);
      check({tag, "_idle_err"}, 32'(align_err_pulse), 32'd0);
    end
  endtask

  // 'between' low cycles, then a one-cycle marker. Checks the main DUT
  // at the marker's sampling edge.
  task automatic marker(input int between, input logic ep, input logic ee,
                        input logic ea, input int ec, input string tag);
    idle_quiet(between, tag);
    cyc(1'b1);
    check({tag, "_pulse"}, 32'(align_pulse), 32'(ep));
    check({tag, "_err"}, 32'(align_err_pulse), 32'(ee));
    check({tag, "_aligned"}, 32'(aligned), 32'(ea));
    check({tag, "_count"}, 32'(err_count), 32'(ec));
  endtask

  // Directed sequence
  initial begin
    fco_in = 1'b0;
    rst_n  = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    check("rst_aligned", 32'(aligned), 32'd0);
    check("rst_pulse", 32'(align_pulse), 32'd0);
    check("rst_err", 32'(align_err_pulse), 32'd0);
    check("rst_count", 32'(err_count), 32'd0);
    check("rst_count_sat", 32'(err_count_s), 32'd0);
    rst_n = 1'b1;

    // Lock: the first marker only arms; the fourth marker completes the lock.
    idle_quiet(3, "pre");
    marker(2, 1'b0, 1'b0, 1'b0, 0, "arm");
    marker(8, 1'b1, 1'b0, 1'b0, 0, "good1");
    marker(8, 1'b1, 1'b0, 1'b0, 0, "good2");
    marker(8, 1'b1, 1'b0, 1'b1, 0, "good3");
    marker(8, 1'b1, 1'b0, 1'b1, 0, "good4");

    // Early marker, 7 cycles after the previous one, then relock.
    marker(6, 1'b0, 1'b1, 1'b0, 1, "early");
    marker(8, 1'b1, 1'b0, 1'b0, 1, "rl1");
    marker(8, 1'b1, 1'b0, 1'b0, 1, "rl2");
    marker(8, 1'b1, 1'b0, 1'b1, 1, "rl3");

    // Missing marker: the timeout fires at the edge where the marker was due.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0);
      check("miss_wait_err", 32'(align_err_pulse), 32'd0);
      check("miss_wait_aligned", 32'(aligned), 32'd1);
    end
    cyc(1'b0);
    check("miss_err", 32'(align_err_pulse), 32'd1);
    check("miss_pulse", 32'(align_pulse), 32'd0);
    check("miss_aligned", 32'(aligned), 32'd0);
    check("miss_count", 32'(err_count), 32'd2);
    idle_quiet(10, "miss_idle");
    check("miss_idle_count", 32'(err_count), 32'd2);
    marker(0, 1'b0, 1'b0, 1'b0, 2, "rearm");
    marker(8, 1'b1, 1'b0, 1'b0, 2, "ml1");
    marker(8, 1'b1, 1'b0, 1'b0, 2, "ml2");
    marker(8, 1'b1, 1'b0, 1'b1, 2, "ml3");

    // Held high: one edge, then a single timeout error.
    marker(8, 1'b1, 1'b0, 1'b1, 2, "hh_edge");
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1);
      check("hh_wait_err", 32'(align_err_pulse), 32'd0);
      check("hh_wait_pulse", 32'(align_pulse), 32'd0);
    end
    cyc(1'b1);
    check("hh_err", 32'(align_err_pulse), 32'd1);
    check("hh_aligned", 32'(aligned), 32'd0);
    check("hh_count", 32'(err_count), 32'd3);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      check("hh_hold_err", 32'(align_err_pulse), 32'd0);
      check("hh_hold_pulse", 32'(align_pulse), 32'd0);
    end
    check("hh_hold_count", 32'(err_count), 32'd3);
    check("hh_count_sat", 32'(err_count_s), 32'd3);
    idle_quiet(4, "hh_drop");

    // Reset while locked, then arm only on the next marker.
    marker(2, 1'b0, 1'b0, 1'b0, 3, "arm3");
    marker(8, 1'b1, 1'b0, 1'b0, 3, "rs1");
    marker(8, 1'b1, 1'b0, 1'b0, 3, "rs2");
    marker(8, 1'b1, 1'b0, 1'b1, 3, "rs3");
    idle_quiet(2, "pre_rst");
    rst_n = 1'b0;
    cyc(1'b0);
    check("mid_rst_aligned", 32'(aligned), 32'd0);
    check("mid_rst_pulse", 32'(align_pulse), 32'd0);
    check("mid_rst_err", 32'(align_err_pulse), 32'd0);
    check("mid_rst_count", 32'(err_count), 32'd0);
    check("mid_rst_count_sat", 32'(err_count_s), 32'd0);
    rst_n = 1'b1;
    marker(3, 1'b0, 1'b0, 1'b0, 0, "post_rst_arm");
    marker(8, 1'b1, 1'b0, 1'b0, 0, "post_rst_good");

    // Saturation: five early markers (4 cycles apart) on both instances.
    for (int i = 0; i < 5; i++) begin
      marker(3, 1'b0, 1'b1, 1'b0, i + 1, "early_n");
      check("sat_err", 32'(align_err_pulse_s), 32'd1);
      check("sat_pulse", 32'(align_pulse_s), 32'd0);
      check("sat_count", 32'(err_count_s), 32'((i + 1 > 3) ? 3 : i + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
